// File: rtl/drawline.sv
// drawline: walks one vertical span, interpolating z/r/g/b per row, and writes RGB565 + 15-bit depth.
// Optional depth-tested write path enabled by defining DRAWLINE_DEPTH_TEST_EN.
module drawline #(
    parameter int FB_H   = 240,
    parameter int SPAN_W = 163
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SPAN_W-1:0] span_data,
    input  logic              span_start,
    output logic              span_done,
    output logic [9:0]        pix_addr,
    output logic              pix_re,
    input  logic [14:0]       pix_zrd,
    output logic              pix_we,
    output logic [30:0]       pix_wdata
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t r_state;
    state_t w_next;

    logic [7:0]  w_y_start;
    logic [7:0]  w_y_end;
    logic [8:0]  w_x;
    logic [23:0] w_z;
    logic [24:0] w_nz;
    logic [13:0] w_r;
    logic [14:0] w_nr;
    logic [14:0] w_g;
    logic [15:0] w_ng;
    logic [13:0] w_b;
    logic [14:0] w_nb;

    assign w_y_start = span_data[162:155];
    assign w_y_end   = span_data[154:147];
    assign w_x       = span_data[146:138];
    assign w_z       = span_data[137:114];
    assign w_nz      = span_data[113:89];
    assign w_r       = span_data[88:75];
    assign w_nr      = span_data[74:60];
    assign w_g       = span_data[59:45];
    assign w_ng      = span_data[44:29];
    assign w_b       = span_data[28:15];
    assign w_nb      = span_data[14:0];

    logic       w_empty;
    logic [7:0] w_y_last;
    assign w_empty  = (w_y_start > w_y_end) || ({1'b0, w_y_start} >= 9'(FB_H));
    assign w_y_last = ({1'b0, w_y_end} >= 9'(FB_H)) ? 8'(FB_H - 1) : w_y_end;

    logic        r_done;
    logic [1:0]  r_x;
    logic [7:0]  r_y;
    logic [7:0]  r_y_last;
    logic [23:0] r_z;
    logic [24:0] r_nz;
    logic [13:0] r_r;
    logic [14:0] r_nr;
    logic [14:0] r_g;
    logic [15:0] r_ng;
    logic [13:0] r_b;
    logic [14:0] r_nb;

    // Accumulator plus signed step; result clamps to [0, max] instead of wrapping.
    function automatic logic [23:0] sat_add(input logic [23:0] acc, input logic [24:0] step,
                                            input logic [23:0] max);
        logic signed [25:0] sum;
        sum = $signed({2'b00, acc}) + $signed({step[24], step});
        if (sum < 0)
            return 24'd0;
        else if (sum > $signed({2'b00, max}))
            return max;
        else
            return sum[23:0];
    endfunction

    logic [23:0] w_z_nxt;
    logic [23:0] w_r_nxt;
    logic [23:0] w_g_nxt;
    logic [23:0] w_b_nxt;
    assign w_z_nxt = sat_add(r_z, r_nz, 24'hFFFFFF);
    assign w_r_nxt = sat_add({10'd0, r_r}, {{10{r_nr[14]}}, r_nr}, 24'h003FFF);
    assign w_g_nxt = sat_add({9'd0, r_g}, {{9{r_ng[15]}}, r_ng}, 24'h007FFF);
    assign w_b_nxt = sat_add({10'd0, r_b}, {{10{r_nb[14]}}, r_nb}, 24'h003FFF);

    logic [30:0] w_pix_data;
    logic [9:0]  w_cur_addr;
    assign w_pix_data = {r_r[13:9], r_g[14:9], r_b[13:9], r_z[23:9]};
    assign w_cur_addr = {r_x, r_y};

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (span_start) w_next = w_empty ? S_DONE : S_RUN;
`ifdef DRAWLINE_DEPTH_TEST_EN
            S_RUN:   if (r_y == r_y_last) w_next = S_DRAIN;
`else
            S_RUN:   if (r_y == r_y_last) w_next = S_DONE;
`endif
            S_DRAIN: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_done   <= 1'b1;
            r_x      <= '0;
            r_y      <= '0;
            r_y_last <= '0;
            r_z      <= '0;
            r_nz     <= '0;
            r_r      <= '0;
            r_nr     <= '0;
            r_g      <= '0;
            r_ng     <= '0;
            r_b      <= '0;
            r_nb     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (span_start) begin
                        r_done   <= 1'b0;
                        r_x      <= w_x[1:0];
                        r_y      <= w_y_start;
                        r_y_last <= w_y_last;
                        r_z      <= w_z;
                        r_nz     <= w_nz;
                        r_r      <= w_r;
                        r_nr     <= w_nr;
                        r_g      <= w_g;
                        r_ng     <= w_ng;
                        r_b      <= w_b;
                        r_nb     <= w_nb;
                    end
                end
                S_RUN: begin
                    r_y <= r_y + 8'd1;
                    r_z <= w_z_nxt;
                    r_r <= w_r_nxt[13:0];
                    r_g <= w_g_nxt[14:0];
                    r_b <= w_b_nxt[13:0];
                end
                S_DONE:  r_done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign span_done = r_done;

`ifdef DRAWLINE_DEPTH_TEST_EN
    // Second stage: the pixel read last cycle is compared against the returned depth.
    logic        r_wr_valid;
    logic [9:0]  r_wr_addr;
    logic [30:0] r_wr_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_valid <= (r_state == S_RUN);
            r_wr_addr  <= w_cur_addr;
            r_wr_data  <= w_pix_data;
        end
    end

    assign pix_re    = (r_state == S_RUN);
    assign pix_we    = r_wr_valid && (r_wr_data[14:0] < pix_zrd);
    assign pix_addr  = r_wr_valid ? r_wr_addr : (pix_re ? w_cur_addr : 10'd0);
    assign pix_wdata = r_wr_valid ? r_wr_data : 31'd0;

    logic w_unused;
    assign w_unused = ^{w_x[8:2], w_r_nxt[23:14], w_g_nxt[23:15], w_b_nxt[23:14]};
`else
    assign pix_re    = 1'b0;
    assign pix_we    = (r_state == S_RUN);
    assign pix_addr  = pix_we ? w_cur_addr : 10'd0;
    assign pix_wdata = pix_we ? w_pix_data : 31'd0;

    logic w_unused;
    assign w_unused = ^{w_x[8:2], pix_zrd, w_r_nxt[23:14], w_g_nxt[23:15], w_b_nxt[23:14]};
`endif

endmodule

// File: tb/tb_drawline.sv
// Bench for drawline: directed and random spans against a closed-form interpolation model.
// Adapts its latency and write expectations to DRAWLINE_DEPTH_TEST_EN.
module tb_drawline;
  localparam int FB_H = 240;
`ifdef DRAWLINE_DEPTH_TEST_EN
  localparam int LAT = 2;
  localparam bit DT  = 1'b1;
`else
  localparam int LAT = 1;
  localparam bit DT  = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [162:0] span_data;
  logic         span_start;
  logic         span_done;
  logic [9:0]   pix_addr;
  logic         pix_re;
  logic [14:0]  pix_zrd;
  logic         pix_we;
  logic [30:0]  pix_wdata;
  logic [14:0]  tb_zrd;

  drawline #(.FB_H(FB_H), .SPAN_W(163)) dut (
    .clk(clk), .rst(rst), .span_data(span_data), .span_start(span_start),
    .span_done(span_done), .pix_addr(pix_addr), .pix_re(pix_re), .pix_zrd(pix_zrd),
    .pix_we(pix_we), .pix_wdata(pix_wdata)
  );

  assign pix_zrd = tb_zrd;

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int c0 = 0;
  int re_cnt = 0;
  // entries: {offset from span_start cycle [48:41], addr [40:31], data [30:0]}
  logic [48:0] exp_q[$];
  logic [48:0] got_q[$];

  always @(negedge clk) begin
    if (pix_we === 1'b1) got_q.push_back({8'(cyc - c0), pix_addr, pix_wdata});
    if (pix_re === 1'b1) re_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [162:0] mk(input logic [7:0] y0, input logic [7:0] y1,
      input logic [8:0] x, input logic [23:0] z, input logic [24:0] nz,
      input logic [13:0] r, input logic [14:0] nr, input logic [14:0] g,
      input logic [15:0] ng, input logic [13:0] b, input logic [14:0] nb);
    return {y0, y1, x, z, nz, r, nr, g, ng, b, nb};
  endfunction

  function automatic longint sx(input logic [24:0] v, input int w);
    longint u;
    u = longint'(v);
    if (v[w-1]) return u - (longint'(1) << w);
    return u;
  endfunction

  function automatic longint clampv(input longint v, input longint mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  // Reference: pixel k = clamp(start + k*step), rows clipped to the frame, depth rule applied.
  task automatic build_exp(input logic [162:0] d, output int n);
    logic [7:0] y0, y1;
    logic [8:0] x;
    longint zv, rv, gv, bv, ylast;
    logic [30:0] data;
    y0 = d[162:155];
    y1 = d[154:147];
    x  = d[146:138];
    exp_q.delete();
    if (y0 > y1 || int'(y0) >= FB_H) n = 0;
    else begin
      ylast = (int'(y1) > FB_H - 1) ? FB_H - 1 : int'(y1);
      n = int'(ylast) - int'(y0) + 1;
    end
    for (int k = 0; k < n; k++) begin
      zv = clampv(longint'(d[137:114]) + k * sx(d[113:89], 25), 64'hFFFFFF);
      rv = clampv(longint'(d[88:75]) + k * sx({10'd0, d[74:60]}, 15), 64'h3FFF);
      gv = clampv(longint'(d[59:45]) + k * sx({9'd0, d[44:29]}, 16), 64'h7FFF);
      bv = clampv(longint'(d[28:15]) + k * sx({10'd0, d[14:0]}, 15), 64'h3FFF);
      data = {5'(rv >> 9), 6'(gv >> 9), 5'(bv >> 9), 15'(zv >> 9)};
      if (!DT || (15'(zv >> 9) < tb_zrd))
        exp_q.push_back({8'(LAT + k), x[1:0], 8'(int'(y0) + k), data});
    end
  endtask

  task automatic run_span(input string tag, input logic [162:0] d, input bit poke);
    int n, low, exp_low;
    build_exp(d, n);
    exp_low = (n == 0) ? 1 : n + LAT;
    got_q.delete();
    re_cnt = 0;
    @(negedge clk);
    span_data  = d;
    span_start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    span_start = 1'b0;
    low = 0;
    while (span_done === 1'b0 && low < 400) begin
      low++;
      if (poke && low == 1) begin
        span_data  = ~d;
        span_start = 1'b1;
      end
      @(negedge clk);
      span_start = 1'b0;
    end
    repeat (2) @(negedge clk);
    check({tag, "_done_low"}, 64'(low), 64'(exp_low));
    check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    check({tag, "_nreads"}, 64'(re_cnt), DT ? 64'(n) : 64'd0);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_wr"}, 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    logic [162:0] d;
    int len;
    rst = 1'b0;
    span_start = 1'b0;
    span_data = '0;
    tb_zrd = 15'd0;
    repeat (3) @(negedge clk);
    check("rst_done", 64'(span_done), 64'd1);
    check("rst_we", 64'(pix_we), 64'd0);
    check("rst_re", 64'(pix_re), 64'd0);
    check("rst_addr", 64'(pix_addr), 64'd0);
    check("rst_wdata", 64'(pix_wdata), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // basic span, with an ignored span_start poke while busy
    tb_zrd = 15'h7FFF;
    run_span("basic", mk(8'd10, 8'd13, 9'd5, 24'd0, 25'd0, 14'h200, 15'h200,
                         15'd0, 16'd0, 14'd0, 15'd0), 1'b1);
    if (got_q.size() == 4) begin
      check("basic_addr0", 64'(got_q[0][40:31]), 64'h10A);
      check("basic_r3", 64'(got_q[3][30:26]), 64'd4);
    end else check("basic_size", 64'(got_q.size()), 64'd4);

    run_span("empty", mk(8'd20, 8'd19, 9'd1, 24'd5, 25'd0, 14'd0, 15'd0,
                         15'd0, 16'd0, 14'd0, 15'd0), 1'b0);
    run_span("clip", mk(8'd236, 8'd250, 9'd2, 24'h1000, 25'h200, 14'd0, 15'd0,
                        15'h3000, 16'h0400, 14'd0, 15'd0), 1'b0);
    check("clip_count", 64'(got_q.size()), 64'd4);
    run_span("clipall", mk(8'd240, 8'd245, 9'd2, 24'd0, 25'd0, 14'd0, 15'd0,
                           15'd0, 16'd0, 14'd0, 15'd0), 1'b0);
    run_span("sat", mk(8'd0, 8'd2, 9'd3, 24'hFFFE00, 25'h0400, 14'h3E00, 15'h0400,
                       15'h0600, 16'hF000, 14'd0, 15'h7E00), 1'b0);
    if (got_q.size() == 3) begin
      check("sat_r2", 64'(got_q[2][30:26]), 64'd31);
      check("sat_b2", 64'(got_q[2][19:15]), 64'd0);
    end else check("sat_size", 64'(got_q.size()), 64'd3);

    // depth test: stored 100 accepts 99, rejects 101; stored 99 rejects equal 99
    tb_zrd = 15'd100;
    run_span("depth", mk(8'd30, 8'd31, 9'd7, 24'(99 << 9), 25'(2 << 9), 14'd0, 15'd0,
                         15'd0, 16'd0, 14'd0, 15'd0), 1'b0);
    tb_zrd = 15'd99;
    run_span("depth_eq", mk(8'd40, 8'd40, 9'd7, 24'(99 << 9), 25'd0, 14'd0, 15'd0,
                            15'd0, 16'd0, 14'd0, 15'd0), 1'b0);

    for (int t = 0; t < 12; t++) begin
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      d[162:155] = 8'($urandom_range(0, 255));
      len = $urandom_range(0, 20);
      if ($urandom_range(0, 7) == 0)
        d[154:147] = d[162:155] - 8'd1;
      else
        d[154:147] = (int'(d[162:155]) + len > 255) ? 8'd255 : 8'(int'(d[162:155]) + len);
      tb_zrd = 15'($urandom);
      run_span("rand", d, 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a 10-pixel span
    tb_zrd = 15'h7FFF;
    got_q.delete();
    @(negedge clk);
    span_data  = mk(8'd50, 8'd59, 9'd6, 24'h400, 25'h200, 14'h200, 15'h200,
                    15'd0, 16'd0, 14'd0, 15'd0);
    span_start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    span_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_we", 64'(pix_we), 64'd0);
    check("mid_rst_done", 64'(span_done), 64'd1);
    check("mid_rst_re", 64'(pix_re), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_writes", 64'(got_q.size()), DT ? 64'd2 : 64'd3);
    check("mid_rst_idle_done", 64'(span_done), 64'd1);

    run_span("after_rst", mk(8'd10, 8'd13, 9'd5, 24'd0, 25'd0, 14'h200, 15'h200,
                             15'd0, 16'd0, 14'd0, 15'd0), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/drawline.md
Name: drawline

Overview:
- Consumes one vertical span from calcline: span_start/span_done handshake, span_data payload.
- Walks the span one pixel per cycle and interpolates z/r/g/b along y.
- Writes RGB565 colour plus 15-bit depth into the frameblock column buffer selected by x[1:0], with an optional depth test.

Parameters:
- FB_H, 240: frame height in rows; rows >= FB_H are clipped.
- SPAN_W, 163: span_data width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- span_data  in  SPAN_W  MSB-first fields: y_start[7:0], y_end[7:0], x[8:0], z[23:0] (15.9), nz[24:0] (s.15.9), r[13:0] (5.9), nr[14:0] (s.5.9), g[14:0] (6.9), ng[15:0] (s.6.9), b[13:0] (5.9), nb[14:0] (s.5.9).
- span_start  in  1  one-cycle pulse; payload is valid in the same cycle.
- span_done  out  1  level; high = idle and ready for a span.
- pix_addr  out  10  {x[1:0], y[7:0]}.
- pix_re  out  1  depth read strobe.
- pix_zrd  in  15  stored depth at pix_addr, valid 1 cycle after pix_re.
- pix_we  out  1  pixel write strobe.
- pix_wdata  out  31  {r[13:9], g[14:9], b[13:9], z[23:9]}.

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, span_done=1, pix_re=0, pix_we=0, pix_addr=0, pix_wdata=0, all accumulators 0. Reset mid-span aborts with no further writes.
- States:
  - IDLE: on span_start, latch all fields and set span_done<=0 on that edge.
    - If y_start > y_end or y_start >= FB_H: go to DONE (empty span).
    - Otherwise go to RUN, with y=y_start and y_last=min(y_end, FB_H-1).
  - RUN: issue one pixel per cycle at row y.
    - Accumulators advance each cycle: z+=nz, r+=nr, g+=ng, b+=nb.
    - y increments; go to DRAIN after issuing y_last.
  - DRAIN: complete the last pixel in flight.
  - DONE: set span_done<=1, return to IDLE.
- Pixel k of a span uses the span values plus k times each step (values refer to row y_start).
- Saturating step:
  - Each add uses a width+1 intermediate.
  - On overflow past the field range, clamp to all-ones if the step is positive and 0 if negative.
  - Examples: r clamps to 14'h3FFF or 0; z clamps to 24'hFFFFFF or 0.
- Pipeline (depth test on):
  - Cycle T: span_start.
  - Cycle T+1+k: pix_re=1, pix_addr for pixel k.
  - Cycle T+2+k: compare; pix_we=1 iff new z[23:9] < pix_zrd, with pix_addr/pix_wdata for pixel k held.
  - span_done=1 at cycle T+3+N for an N-pixel span.
- Empty span: span_done returns high at T+2; no pix_re, no pix_we.
- span_start while span_done=0: ignored; latched state is unchanged.
- Addresses within one span are distinct rows, so there is no read-after-write hazard.
- Back-to-back spans are separated by at least one IDLE cycle.
- Colour truncation: drop the 9 fraction bits, no rounding.

Optional Feature:
- Macro: DRAWLINE_DEPTH_TEST_EN.
- Defined: depth read/compare pipeline as above; equal z is rejected; pix_re is driven.
- Undefined:
  - pix_re tied 0 and pix_zrd ignored.
  - Every pixel is written unconditionally, one stage shorter: pix_we at T+1+k.
  - span_done high at T+2+N.

Test Plan:
- Basic span: y_start=10, y_end=13, x=5, r=1<<9, nr=1<<9, others 0, depth off.
  - Expect writes at addr {2'b01, 10..13} with r field 1,2,3,4.
  - span_done low for exactly 5 cycles after span_start.
- Empty span: y_start=20, y_end=19 -> no pix_we/pix_re; span_done high 2 cycles after span_start.
- Clip: y_start=236, y_end=250, FB_H=240 -> exactly 4 writes, rows 236..239.
- Saturation: r=14'h3E00, nr=15'h0400 -> r field 31,31,31; nb negative with b=0 -> b field stays 0.
- Depth (macro on): pix_zrd returns 100 for all rows, span z=(99 then 101)<<9 via nz=2<<9.
  - Expect first pixel written, second not.
  - Stored z equal to 99 -> not written.
- Reset mid-span: assert rst=0 at pixel 2 of a 10-pixel span.
  - pix_we=0 from the next cycle on; span_done=1.
  - A new span_start after release is accepted normally.
